// File: rtl/tug_playfield.sv
// Tug-of-war playfield: one lit position moved by left/right presses, with a round FSM and saturating scores.
// Optional TUG_AUTO_RESTART_EN: win states return to PLAY after RESTART_CYCLES cycles.
module tug_playfield #(
    parameter int NUM_LIGHTS     = 9,
    parameter int SCORE_W        = 3,
    parameter int RESTART_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  L,
    input  logic                  R,
    output logic [NUM_LIGHTS-1:0] lights,
    output logic                  winner_l,
    output logic                  winner_r,
    output logic [SCORE_W-1:0]    score_l,
    output logic [SCORE_W-1:0]    score_r
);

    // state | meaning
    // PLAY  | lit position moves with presses
    // WIN_L | left pushed the light off the left end; presses ignored
    // WIN_R | right pushed the light off the right end; presses ignored
    typedef enum logic [1:0] {PLAY = 2'd0, WIN_L = 2'd1, WIN_R = 2'd2} state_t;

    localparam int POS_W = $clog2(NUM_LIGHTS);
    localparam logic [POS_W-1:0]   CENTER    = POS_W'((NUM_LIGHTS - 1) / 2);
    localparam logic [POS_W-1:0]   LAST      = POS_W'(NUM_LIGHTS - 1);
    localparam logic [SCORE_W-1:0] SCORE_MAX = {SCORE_W{1'b1}};

    state_t             state_q, state_d;
    logic [POS_W-1:0]   pos_q, pos_d;
    logic [SCORE_W-1:0] score_l_q, score_l_d;
    logic [SCORE_W-1:0] score_r_q, score_r_d;

`ifdef TUG_AUTO_RESTART_EN
    localparam int CNT_W = (RESTART_CYCLES > 1) ? $clog2(RESTART_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(RESTART_CYCLES - 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= PLAY;
            pos_q     <= CENTER;
            score_l_q <= '0;
            score_r_q <= '0;
`ifdef TUG_AUTO_RESTART_EN
            cnt_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            pos_q     <= pos_d;
            score_l_q <= score_l_d;
            score_r_q <= score_r_d;
`ifdef TUG_AUTO_RESTART_EN
            cnt_q     <= cnt_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        pos_d     = pos_q;
        score_l_d = score_l_q;
        score_r_d = score_r_q;
`ifdef TUG_AUTO_RESTART_EN
        cnt_d     = cnt_q;
`endif
        case (state_q)
            PLAY: begin
                // simultaneous presses cancel
                if (L && !R) begin
                    if (pos_q == LAST) begin
                        state_d = WIN_L;
                        if (score_l_q != SCORE_MAX) score_l_d = score_l_q + 1'b1;
`ifdef TUG_AUTO_RESTART_EN
                        cnt_d = CNT_LOAD;
`endif
                    end else begin
                        pos_d = pos_q + 1'b1;
                    end
                end else if (R && !L) begin
                    if (pos_q == '0) begin
                        state_d = WIN_R;
                        if (score_r_q != SCORE_MAX) score_r_d = score_r_q + 1'b1;
`ifdef TUG_AUTO_RESTART_EN
                        cnt_d = CNT_LOAD;
`endif
                    end else begin
                        pos_d = pos_q - 1'b1;
                    end
                end
            end
            WIN_L, WIN_R: begin
`ifdef TUG_AUTO_RESTART_EN
                if (cnt_q == '0) begin
                    state_d = PLAY;
                    pos_d   = CENTER;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
`endif
            end
            default: begin
                state_d = PLAY;
                pos_d   = CENTER;
            end
        endcase
    end

    always_comb begin
        winner_l = (state_q == WIN_L);
        winner_r = (state_q == WIN_R);
        lights   = '0;
        if (state_q == PLAY) lights = NUM_LIGHTS'(1) << pos_q;
        score_l  = score_l_q;
        score_r  = score_r_q;
    end

endmodule

// File: doc/tug_playfield.md
# tug_playfield

Parametrised tug-of-war playfield: a row of `NUM_LIGHTS` lights with exactly one lit. Player presses move the lit position; pushing it off either end wins the round. Replaces the per-light neighbour cells with a single position register, a round state machine and per-player score counters. Sits between the upstream press edge detectors (one per player) and the LED/HEX display drivers.

## Interface
Parameters:
- `NUM_LIGHTS`, default 9: number of lights. Odd, ≥3.
- `SCORE_W`, default 3: width of each score counter.
- `RESTART_CYCLES`, default 4: win-display duration before auto-restart. Only used with `TUG_AUTO_RESTART_EN`. ≥1.

Ports:
- `clk` in 1: system clock.
- `reset` in 1: synchronous, active-high reset.
- `L` in 1: left-player press. One-cycle pulse from the upstream edge detector.
- `R` in 1: right-player press. One-cycle pulse.
- `lights` out `NUM_LIGHTS`: one-hot lit position. Bit `NUM_LIGHTS-1` is the leftmost light, bit 0 the rightmost.
- `winner_l` out 1: left player won the current round.
- `winner_r` out 1: right player won the current round.
- `score_l` out `SCORE_W`: left rounds won.
- `score_r` out `SCORE_W`: right rounds won.

One clock; reset is synchronous and active-high.

## Operation
- Position register `pos`, width `$clog2(NUM_LIGHTS)`.
- `CENTER = (NUM_LIGHTS-1)/2`.
- `lights` is a decode of `pos` while in PLAY. It is all zeros in WIN_L and WIN_R.
- State machine `{PLAY, WIN_L, WIN_R}`.
- PLAY transitions:
  - `L & ~R` and `pos < NUM_LIGHTS-1`: `pos <= pos+1`.
  - `L & ~R` and `pos == NUM_LIGHTS-1`: go to WIN_L and increment `score_l`.
  - `R & ~L` and `pos > 0`: `pos <= pos-1`.
  - `R & ~L` and `pos == 0`: go to WIN_R and increment `score_r`.
  - `L & R`, or neither pressed: no change. Simultaneous presses cancel.
- In WIN_L and WIN_R, `L` and `R` are ignored.
- `winner_l` = (state == WIN_L). `winner_r` = (state == WIN_R). The two are never both 1.
- Score counters saturate at `2**SCORE_W-1`. A win at saturation still enters the win state; the score holds.
- Reset values: state PLAY, `pos = CENTER`, `lights` = one-hot at CENTER, `winner_l = winner_r = 0`, both scores 0.
- Reset has priority over every event, including a press in the same cycle and reset during a win state.

## Timing
- Press sampled at edge N: `lights` and `pos` reflect it after edge N.
- Press sampled at edge N that causes a win: winner flag and score are updated after edge N, and `lights` goes to 0 after the same edge.
- Back-to-back pulses on consecutive cycles each move one position. There is no minimum spacing.
- The win state is held until reset, or until auto-restart when `TUG_AUTO_RESTART_EN` is defined.
- Auto-restart:
  - A down-counter loads `RESTART_CYCLES-1` on win entry.
  - When it reaches 0 the block returns to PLAY with `pos = CENTER`.
  - The winner flag is therefore high for exactly `RESTART_CYCLES` cycles.
  - Scores are kept across the restart.
  - A press on the restart cycle is ignored. The first press that takes effect is sampled on the cycle after `lights` shows CENTER again.

## Configuration
- Macro `TUG_AUTO_RESTART_EN`.
- Defined: WIN_L/WIN_R return to PLAY after `RESTART_CYCLES` cycles, as in Timing. Supports multi-round play with accumulating scores.
- Undefined: no restart counter is compiled in and `RESTART_CYCLES` is unused. WIN_L/WIN_R are terminal until `reset`. Each score reaches at most 1 per reset.

## Test plan
All scenarios use `NUM_LIGHTS=9` and `SCORE_W=3`.
- Reset with presses held high -> `lights = 9'b000010000`, both winner flags 0, both scores 0. The state is held while reset is asserted.
- Four `L` pulses from reset -> `lights` steps through bits 5, 6, 7, 8. A fifth `L` -> `winner_l = 1`, `lights = 0`, `score_l = 1`.
- `L` and `R` high in the same cycle, repeated 3 times -> `lights` stays at bit 4. Then one `R` -> bit 3.
- Five `R` pulses, then `L` during WIN_R -> `winner_r` stays 1, `score_r = 1`, `lights` stays 0.
- With `TUG_AUTO_RESTART_EN` and `RESTART_CYCLES=4`: after a left win, `winner_l` is high for exactly 4 cycles, then `lights = bit 4` and `score_l` is kept. Repeat 8 wins -> `score_l` saturates at 7.
- Reset asserted during WIN_L -> next cycle is PLAY, `lights = bit 4`, both scores 0.
